alu_reservation_station: RTL

Holds up to DEPTH ALU micro-ops written by the dispatch stage (up to two per cycle) and captures missing source operands from the result broadcast buses. Each cycle it issues the oldest fully-ready entry to the ALU. It reports one-slot and two-slot availability back to dispatch. It sits between dispatch and the ALU execute stage.

---
 rtl/rs_pkg.sv | 74 +++++++
 rtl/alu_reservation_station_if.sv | 36 +++
 rtl/rs_wakeup.sv | 33 +++
 rtl/alu_reservation_station.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the ALU reservation station: dispatch write
// formats, the stored entry layout and the result broadcast bus ordering.
package rs_pkg;

  localparam int unsigned TAGW = 6;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBC  = 3;

  localparam int unsigned BC_ALU = 0;
  localparam int unsigned BC_SFU = 1;
  localparam int unsigned BC_AGU = 2;

  typedef struct packed {
    logic [XLEN-1:0] src1;
    logic [TAGW-1:0] rob;
    logic [TAGW-1:0] tag2;
    logic [TAGW-1:0] tag1;
    logic            rdy2;
    logic            rdy1;
  } rs_must_t;

  typedef struct packed {
    logic [2:0]      ctrl;
    logic [XLEN-1:0] src2;
  } rs_data_t;

  typedef struct packed {
    logic            valid;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [TAGW-1:0] tag1;
    logic [TAGW-1:0] tag2;
    logic            rdy1;
    logic            rdy2;
    logic [TAGW-1:0] rob;
  } alu_rs_entry_t;

  function automatic alu_rs_entry_t make_entry(input rs_must_t m, input rs_data_t d);
    alu_rs_entry_t e;
    e.valid = 1'b1;
    e.ctrl  = d.ctrl;
    e.src1  = m.src1;
    e.src2  = d.src2;
    e.tag1  = m.tag1;
    e.tag2  = m.tag2;
    e.rdy1  = m.rdy1;
    e.rdy2  = m.rdy2;
    e.rob   = m.rob;
    return e;
  endfunction

  // Only a valid entry still waiting on an operand captures broadcast data.
  function automatic alu_rs_entry_t apply_wake(
    input alu_rs_entry_t   e,
    input logic            hit1,
    input logic [XLEN-1:0] data1,
    input logic            hit2,
    input logic [XLEN-1:0] data2
  );
    alu_rs_entry_t w;
    w = e;
    if (e.valid && !e.rdy1 && hit1) begin
      w.rdy1 = 1'b1;
      w.src1 = data1;
    end
    if (e.valid && !e.rdy2 && hit2) begin
      w.rdy2 = 1'b1;
      w.src2 = data2;
    end
    return w;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, broadcast and issue signals of the ALU reservation station.
// master = surrounding pipeline, slave = the reservation station.
interface alu_reservation_station_if;
  import rs_pkg::*;

  logic                      flush;
  logic                      wr_en;
  logic                      wr_two;
  rs_must_t                  wr0_must;
  rs_data_t                  wr0_data;
  rs_must_t                  wr1_must;
  rs_data_t                  wr1_data;
  logic                      free_1;
  logic                      free_2;
  logic [NBC-1:0]            bc_valid;
  logic [NBC-1:0][TAGW-1:0]  bc_tag;
  logic [NBC-1:0][XLEN-1:0]  bc_data;
  logic                      fu_ready;
  logic                      iss_valid;
  logic [2:0]                iss_ctrl;
  logic [XLEN-1:0]           iss_src1;
  logic [XLEN-1:0]           iss_src2;
  logic [TAGW-1:0]           iss_rob;

  modport master (
    output flush, wr_en, wr_two, wr0_must, wr0_data, wr1_must, wr1_data,
    output bc_valid, bc_tag, bc_data, fu_ready,
    input  free_1, free_2, iss_valid, iss_ctrl, iss_src1, iss_src2, iss_rob
  );

  modport slave (
    input  flush, wr_en, wr_two, wr0_must, wr0_data, wr1_must, wr1_data,
    input  bc_valid, bc_tag, bc_data, fu_ready,
    output free_1, free_2, iss_valid, iss_ctrl, iss_src1, iss_src2, iss_rob
  );
endinterface

// File: rtl/rs_wakeup.sv
// One operand's tag match against the result broadcast buses; when several
// buses match, the ALU bus wins over SFU, which wins over AGU.
module rs_wakeup
  import rs_pkg::*;
#(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [NBC-1:0]              bc_valid,
  input  logic [NBC-1:0][TAG_W-1:0]   bc_tag,
  input  logic [NBC-1:0][DATA_W-1:0]  bc_data,
  output logic                        hit,
  output logic [DATA_W-1:0]           data
);

  logic [NBC-1:0] match;

  always_comb begin
    for (int unsigned i = 0; i < NBC; i++) begin
      match[i] = bc_valid[i] && (bc_tag[i] == tag);
    end
  end

  always_comb begin
    hit  = |match;
    data = '0;
    if (match[BC_ALU])      data = bc_data[BC_ALU];
    else if (match[BC_SFU]) data = bc_data[BC_SFU];
    else if (match[BC_AGU]) data = bc_data[BC_AGU];
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Compacting age-ordered reservation station for the ALU: slot 0 is the
// oldest entry; issues the oldest fully-ready entry each cycle.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAGW  = 6
) (
  input logic                       clk,
  input logic                       reset,
  alu_reservation_station_if.slave  rs
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(DEPTH);
  localparam int unsigned NC = DEPTH + 2;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] FREE1_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FREE2_MAX = CW'(DEPTH - 2);

  alu_rs_entry_t   ent   [DEPTH];
  alu_rs_entry_t   nxt   [DEPTH];
  alu_rs_entry_t   cand  [NC];
  alu_rs_entry_t   woke  [NC];
  logic [NC-1:0]   hit1, hit2;
  logic [XLEN-1:0] data1 [NC];
  logic [XLEN-1:0] data2 [NC];

  logic [CW-1:0]   count, count_nxt, base;
  logic [SW-1:0]   sel;
  logic            any_ready, fire, wr0_ok, wr1_ok;

  // Stored slots followed by the two incoming writes, so every operand
  // (held or arriving) snoops the broadcast through the same path.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cand[i] = ent[i];
    end
    cand[DEPTH]     = make_entry(rs.wr0_must, rs.wr0_data);
    cand[DEPTH + 1] = make_entry(rs.wr1_must, rs.wr1_data);
  end

  for (genvar g = 0; g < NC; g++) begin : g_wake
    rs_wakeup #(.TAG_W(TAGW), .DATA_W(XLEN)) u_wake1 (
      .tag      (cand[g].tag1),
      .bc_valid (rs.bc_valid),
      .bc_tag   (rs.bc_tag),
      .bc_data  (rs.bc_data),
      .hit      (hit1[g]),
      .data     (data1[g])
    );
    rs_wakeup #(.TAG_W(TAGW), .DATA_W(XLEN)) u_wake2 (
      .tag      (cand[g].tag2),
      .bc_valid (rs.bc_valid),
      .bc_tag   (rs.bc_tag),
      .bc_data  (rs.bc_data),
      .hit      (hit2[g]),
      .data     (data2[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NC; i++) begin
      woke[i] = apply_wake(cand[i], hit1[i], data1[i], hit2[i], data2[i]);
    end
  end

  // Select works on registered state only, so a wakeup is issuable next cycle.
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!any_ready && ent[i].valid && ent[i].rdy1 && ent[i].rdy2) begin
        any_ready = 1'b1;
        sel       = SW'(i);
      end
    end
  end

  assign fire = any_ready && rs.fu_ready;

  always_comb begin
    rs.iss_valid = any_ready;
    rs.iss_ctrl  = '0;
    rs.iss_src1  = '0;
    rs.iss_src2  = '0;
    rs.iss_rob   = '0;
    if (any_ready) begin
      rs.iss_ctrl = ent[sel].ctrl;
      rs.iss_src1 = ent[sel].src1;
      rs.iss_src2 = ent[sel].src2;
      rs.iss_rob  = ent[sel].rob;
    end
  end

  assign rs.free_1 = (count <= FREE1_MAX);
  assign rs.free_2 = (count <= FREE2_MAX);

  // Shift down over the issued slot first, then append at the new tail.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt[i] = woke[i];
    end
    if (fire) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= CW'(sel)) nxt[i] = woke[i + 1];
      end
      nxt[DEPTH - 1] = '0;
    end

    base   = count - CW'(fire);
    wr0_ok = rs.wr_en && (base < FULL);
    wr1_ok = rs.wr_en && rs.wr_two && ((base + CW'(1)) < FULL);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr0_ok && (CW'(i) == base))          nxt[i] = woke[DEPTH];
      if (wr1_ok && (CW'(i) == base + CW'(1))) nxt[i] = woke[DEPTH + 1];
    end
    count_nxt = base + CW'(wr0_ok) + CW'(wr1_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (rs.flush) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i] <= nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !rs.flush && rs.wr_en) begin
      assert ((base < FULL) && (!rs.wr_two || ((base + CW'(1)) < FULL)));
    end
  end

endmodule
